// File: rtl/processor_core_if.sv
// Bus bundle between the core and its shared instruction/data memory.
// The master side is the core; the slave side is the memory block.
interface processor_core_if;
    logic [31:0] instr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic [31:0] inst_addr;
    logic [31:0] data_addr;
    logic        mem_read_ctrlsig;
    logic        mem_write_ctrlsig;

    modport master (
        input  instr,
        input  data_out,
        output data_in,
        output inst_addr,
        output data_addr,
        output mem_read_ctrlsig,
        output mem_write_ctrlsig
    );

    modport slave (
        output instr,
        output data_out,
        input  data_in,
        input  inst_addr,
        input  data_addr,
        input  mem_read_ctrlsig,
        input  mem_write_ctrlsig
    );
endinterface

// File: rtl/processor_core.sv
// Single-cycle 32-bit MIPS-subset core.
// One instruction is fetched and executed per enabled clock. All bus outputs
// are combinational from the PC, the current instruction word and the register
// file; the only state is the PC and the 32x32 register file.
module processor_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                pc_reset,
    input  logic                pc_enable,
    processor_core_if.master    bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // Architectural state
    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    // Instruction fields
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_jidx;

    assign w_op    = bus.instr[31:26];
    assign w_rs    = bus.instr[25:21];
    assign w_rt    = bus.instr[20:16];
    assign w_rd    = bus.instr[15:11];
    assign w_shamt = bus.instr[10:6];
    assign w_funct = bus.instr[5:0];
    assign w_imm   = bus.instr[15:0];
    assign w_jidx  = bus.instr[25:0];

    // Decoded controls
    logic        w_reg_write;
    logic [4:0]  w_dst;
    logic        w_use_imm;
    logic        w_imm_zext;
    alu_op_t     w_alu_op;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_j;

    // Datapath
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_imm_ext;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic [31:0] w_wb_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_next_pc;
    logic        w_branch_taken;

    // Decode opcode/funct into datapath controls; anything unrecognised
    // leaves every control at its NOP default. R-type ALU ops with a nonzero
    // shamt field are non-canonical encodings and are also treated as NOP.
    always_comb begin
        w_reg_write = 1'b0;
        w_dst       = w_rt;
        w_use_imm   = 1'b0;
        w_imm_zext  = 1'b0;
        w_alu_op    = ALU_ADD;
        w_is_lw     = 1'b0;
        w_is_sw     = 1'b0;
        w_is_beq    = 1'b0;
        w_is_bne    = 1'b0;
        w_is_j      = 1'b0;
        unique case (w_op)
            OP_RTYPE: begin
                w_dst = w_rd;
                if (w_shamt == 5'd0) begin
                    unique case (w_funct)
                        FN_ADD: begin w_reg_write = 1'b1; w_alu_op = ALU_ADD; end
                        FN_SUB: begin w_reg_write = 1'b1; w_alu_op = ALU_SUB; end
                        FN_AND: begin w_reg_write = 1'b1; w_alu_op = ALU_AND; end
                        FN_OR:  begin w_reg_write = 1'b1; w_alu_op = ALU_OR;  end
                        FN_SLT: begin w_reg_write = 1'b1; w_alu_op = ALU_SLT; end
                        default: ;
                    endcase
                end
            end
            OP_ADDI: begin
                w_reg_write = 1'b1;
                w_use_imm   = 1'b1;
                w_alu_op    = ALU_ADD;
            end
            OP_ANDI: begin
                w_reg_write = 1'b1;
                w_use_imm   = 1'b1;
                w_imm_zext  = 1'b1;
                w_alu_op    = ALU_AND;
            end
            OP_ORI: begin
                w_reg_write = 1'b1;
                w_use_imm   = 1'b1;
                w_imm_zext  = 1'b1;
                w_alu_op    = ALU_OR;
            end
            OP_LW: begin
                w_reg_write = 1'b1;
                w_use_imm   = 1'b1;
                w_is_lw     = 1'b1;
            end
            OP_SW: begin
                w_use_imm   = 1'b1;
                w_is_sw     = 1'b1;
            end
            OP_BEQ: begin
                w_is_beq    = 1'b1;
                w_alu_op    = ALU_SUB;
            end
            OP_BNE: begin
                w_is_bne    = 1'b1;
                w_alu_op    = ALU_SUB;
            end
            OP_J: begin
                w_is_j      = 1'b1;
            end
            default: ;
        endcase
    end

    // $0 is hardwired to zero on both read ports.
    assign w_rs_val  = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
    assign w_rt_val  = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];

    assign w_imm_ext = w_imm_zext ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};
    assign w_alu_b   = w_use_imm ? w_imm_ext : w_rt_val;

    // ALU: wrap-around arithmetic, signed set-less-than.
    always_comb begin
        w_alu_res = 32'h0;
        unique case (w_alu_op)
            ALU_ADD: w_alu_res = w_rs_val + w_alu_b;
            ALU_SUB: w_alu_res = w_rs_val - w_alu_b;
            ALU_AND: w_alu_res = w_rs_val & w_alu_b;
            ALU_OR:  w_alu_res = w_rs_val | w_alu_b;
            ALU_SLT: w_alu_res = ($signed(w_rs_val) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
            default: w_alu_res = 32'h0;
        endcase
    end

    assign w_wb_data = w_is_lw ? bus.data_out : w_alu_res;

    // Next-PC selection
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + {w_imm_ext[29:0], 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], w_jidx, 2'b00};
    assign w_branch_taken  = (w_is_beq && (w_rs_val == w_rt_val)) ||
                             (w_is_bne && (w_rs_val != w_rt_val));

    // Pick the successor PC: jump, taken branch, or sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_is_j) begin
            w_next_pc = w_jump_target;
        end else if (w_branch_taken) begin
            w_next_pc = w_branch_target;
        end
    end

    // Bus outputs; the write strobe is suppressed while stalled so the
    // memory never captures a store that the core has not committed.
    assign bus.inst_addr         = r_pc;
    assign bus.data_addr         = w_alu_res;
    assign bus.data_in           = w_rt_val;
    assign bus.mem_read_ctrlsig  = w_is_lw;
    assign bus.mem_write_ctrlsig = w_is_sw & pc_enable;

    // Commit PC and register write-back; reset wins over enable.
    always_ff @(posedge clk) begin
        if (pc_reset) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (pc_enable) begin
            r_pc <= w_next_pc;
            if (w_reg_write && (w_dst != 5'd0)) begin
                r_regs[w_dst] <= w_wb_data;
            end
        end
    end

endmodule

// File: tb/tb_processor_core.sv
// Directed testbench for processor_core. The bench plays instruction memory
// by driving instr directly and models the data memory itself.
module tb_processor_core;

    logic clk;
    logic pc_reset;
    logic pc_enable;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    logic [31:0] mem [0:63] = '{default: 32'h0};

    processor_core_if bus ();

    processor_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .pc_reset  (pc_reset),
        .pc_enable (pc_enable),
        .bus       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: combinational read, write at the clock edge.
    always_comb bus.data_out = mem[bus.data_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_write_ctrlsig) begin
            mem[bus.data_addr[7:2]] <= bus.data_in;
            wr_count <= wr_count + 1;
        end
    end

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step(input logic [31:0] ins);
        bus.instr = ins;
        pc_enable = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Read a register without changing state: a stalled sw exposes rt on data_in.
    task automatic peek(input logic [4:0] r, output logic [31:0] val);
        pc_enable = 1'b0;
        bus.instr = itype(6'h2B, 5'd0, r, 16'h0);
        #1;
        val = bus.data_in;
        bus.instr = 32'h0;
        pc_enable = 1'b1;
    endtask

    task automatic do_reset();
        pc_reset  = 1'b1;
        pc_enable = 1'b1;
        bus.instr = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        pc_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        checks++;
        if (bus.inst_addr !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", bus.inst_addr, 32'h0);
        end
        checks++;
        if ({bus.mem_read_ctrlsig, bus.mem_write_ctrlsig} !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00",
                               {bus.mem_read_ctrlsig, bus.mem_write_ctrlsig});
        end
        checks++;
        if (bus.data_addr !== 32'h0) begin
            errors++; $display("FAIL reset_data_addr: got %h expected %h", bus.data_addr, 32'h0);
        end
        for (int r = 0; r < 32; r++) begin
            peek(r[4:0], v);
            checks++;
            if (v !== 32'h0) begin
                errors++; $display("FAIL reset_reg%0d: got %h expected %h", r, v, 32'h0);
            end
        end
        step(32'h0);
        checks++;
        if (bus.inst_addr !== 32'h4) begin
            errors++; $display("FAIL pc_seq1: got %h expected %h", bus.inst_addr, 32'h4);
        end
        step(32'h0);
        checks++;
        if (bus.inst_addr !== 32'h8) begin
            errors++; $display("FAIL pc_seq2: got %h expected %h", bus.inst_addr, 32'h8);
        end
    endtask

    task automatic test_alu();
        logic [31:0] v;
        logic [4:0]  exp_reg [9];
        logic [31:0] exp_val [9];
        exp_reg = '{5'd3, 5'd4, 5'd5, 5'd11, 5'd7, 5'd8, 5'd9, 5'd10, 5'd13};
        exp_val = '{32'h2, 32'hFFFF_FFF8, 32'h1, 32'h0, 32'h0000_FFFF,
                    32'h0000_FFFD, 32'h0000_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFB};
        do_reset();
        step(itype(6'h08, 5'd0, 5'd1, 16'd5));
        step(itype(6'h08, 5'd0, 5'd2, 16'hFFFD));
        bus.instr = rtype(6'h20, 5'd1, 5'd2, 5'd3);
        #1;
        checks++;
        if (bus.data_addr !== 32'h2) begin
            errors++; $display("FAIL alu_add_result: got %h expected %h", bus.data_addr, 32'h2);
        end
        step(rtype(6'h20, 5'd1, 5'd2, 5'd3));
        step(rtype(6'h22, 5'd2, 5'd1, 5'd4));
        step(rtype(6'h2A, 5'd2, 5'd1, 5'd5));
        step(rtype(6'h2A, 5'd1, 5'd2, 5'd11));
        step(itype(6'h0D, 5'd0, 5'd7, 16'hFFFF));
        step(itype(6'h0C, 5'd2, 5'd8, 16'hFFFF));
        step(rtype(6'h24, 5'd2, 5'd7, 5'd9));
        step(rtype(6'h25, 5'd1, 5'd2, 5'd10));
        step(rtype(6'h22, 5'd0, 5'd1, 5'd13));
        for (int k = 0; k < 9; k++) begin
            peek(exp_reg[k], v);
            checks++;
            if (v !== exp_val[k]) begin
                errors++; $display("FAIL alu_reg%0d: got %h expected %h", exp_reg[k], v, exp_val[k]);
            end
        end
    endtask

    task automatic test_mem_and_stall();
        logic [31:0] v;
        int wc0;
        do_reset();
        step(itype(6'h08, 5'd0, 5'd1, 16'h0040));
        wc0 = wr_count;
        bus.instr = itype(6'h2B, 5'd1, 5'd1, 16'd4);
        pc_enable = 1'b1;
        #1;
        checks++;
        if ({bus.data_addr, bus.data_in, bus.mem_write_ctrlsig, bus.mem_read_ctrlsig}
            !== {32'h44, 32'h40, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sw_bus: got addr=%h din=%h wr=%b rd=%b expected addr=44 din=40 wr=1 rd=0",
                               bus.data_addr, bus.data_in, bus.mem_write_ctrlsig, bus.mem_read_ctrlsig);
        end
        pc_enable = 1'b0;
        #1;
        checks++;
        if (bus.mem_write_ctrlsig !== 1'b0) begin
            errors++; $display("FAIL stall_wr_strobe: got %b expected 0", bus.mem_write_ctrlsig);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.inst_addr !== 32'h4) begin
            errors++; $display("FAIL stall_pc: got %h expected %h", bus.inst_addr, 32'h4);
        end
        checks++;
        if (wr_count !== wc0) begin
            errors++; $display("FAIL stall_no_write: got %0d writes expected %0d", wr_count, wc0);
        end
        peek(5'd1, v);
        checks++;
        if (v !== 32'h40) begin
            errors++; $display("FAIL stall_reg1: got %h expected %h", v, 32'h40);
        end
        step(itype(6'h2B, 5'd1, 5'd1, 16'd4));
        checks++;
        if (mem[17] !== 32'h40 || wr_count !== wc0 + 1) begin
            errors++; $display("FAIL sw_commit: got mem=%h writes=%0d expected mem=40 writes=%0d",
                               mem[17], wr_count, wc0 + 1);
        end
        checks++;
        if (bus.inst_addr !== 32'h8) begin
            errors++; $display("FAIL sw_pc: got %h expected %h", bus.inst_addr, 32'h8);
        end
        bus.instr = itype(6'h23, 5'd1, 5'd6, 16'd4);
        #1;
        checks++;
        if ({bus.mem_read_ctrlsig, bus.mem_write_ctrlsig, bus.data_addr} !== {1'b1, 1'b0, 32'h44}) begin
            errors++; $display("FAIL lw_bus: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=44",
                               bus.mem_read_ctrlsig, bus.mem_write_ctrlsig, bus.data_addr);
        end
        step(itype(6'h23, 5'd1, 5'd6, 16'd4));
        peek(5'd6, v);
        checks++;
        if (v !== 32'h40) begin
            errors++; $display("FAIL lw_reg6: got %h expected %h", v, 32'h40);
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] exp_pc [7];
        logic [31:0] ins [7];
        do_reset();
        repeat (4) step(32'h0);
        checks++;
        if (bus.inst_addr !== 32'h10) begin
            errors++; $display("FAIL br_setup_pc: got %h expected %h", bus.inst_addr, 32'h10);
        end
        ins    = '{itype(6'h04, 5'd0, 5'd0, 16'd2),
                   itype(6'h05, 5'd0, 5'd0, 16'd2),
                   {6'h02, 26'h100},
                   itype(6'h08, 5'd0, 5'd1, 16'd1),
                   itype(6'h04, 5'd1, 5'd0, 16'd2),
                   itype(6'h05, 5'd1, 5'd0, 16'hFFFF),
                   itype(6'h05, 5'd1, 5'd0, 16'd3)};
        exp_pc = '{32'h1C, 32'h20, 32'h400, 32'h404, 32'h408, 32'h408, 32'h418};
        for (int k = 0; k < 7; k++) begin
            step(ins[k]);
            checks++;
            if (bus.inst_addr !== exp_pc[k]) begin
                errors++; $display("FAIL br_step%0d: got %h expected %h", k, bus.inst_addr, exp_pc[k]);
            end
        end
    endtask

    task automatic test_zero_and_nop();
        logic [31:0] v;
        do_reset();
        step(itype(6'h08, 5'd0, 5'd0, 16'd7));
        peek(5'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL reg0_write: got %h expected %h", v, 32'h0);
        end
        step(itype(6'h08, 5'd0, 5'd1, 16'd3));
        bus.instr = itype(6'h3F, 5'd1, 5'd16, 16'd5);
        #1;
        checks++;
        if ({bus.mem_read_ctrlsig, bus.mem_write_ctrlsig} !== 2'b00) begin
            errors++; $display("FAIL badop_strobes: got %b expected 00",
                               {bus.mem_read_ctrlsig, bus.mem_write_ctrlsig});
        end
        step(itype(6'h3F, 5'd1, 5'd16, 16'd5));
        checks++;
        if (bus.inst_addr !== 32'hC) begin
            errors++; $display("FAIL badop_pc: got %h expected %h", bus.inst_addr, 32'hC);
        end
        step(rtype(6'h3F, 5'd1, 5'd1, 5'd15));
        peek(5'd16, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL badop_reg16: got %h expected %h", v, 32'h0);
        end
        peek(5'd15, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL badfn_reg15: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        do_reset();
        step(itype(6'h08, 5'd0, 5'd1, 16'd9));
        repeat (11) step(32'h0);
        checks++;
        if (bus.inst_addr !== 32'h30) begin
            errors++; $display("FAIL mid_setup_pc: got %h expected %h", bus.inst_addr, 32'h30);
        end
        pc_reset  = 1'b1;
        pc_enable = 1'b1;
        bus.instr = itype(6'h08, 5'd0, 5'd2, 16'd7);
        @(posedge clk);
        #1;
        pc_reset = 1'b0;
        checks++;
        if (bus.inst_addr !== 32'h0) begin
            errors++; $display("FAIL mid_reset_pc: got %h expected %h", bus.inst_addr, 32'h0);
        end
        peek(5'd1, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL mid_reset_reg1: got %h expected %h", v, 32'h0);
        end
        peek(5'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL mid_reset_reg2: got %h expected %h", v, 32'h0);
        end
    endtask

    initial begin
        pc_reset  = 1'b1;
        pc_enable = 1'b1;
        bus.instr = 32'h0;
        test_reset();
        test_alu();
        test_mem_and_stall();
        test_branch_jump();
        test_zero_and_nop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
